// File: rtl/boot_loader.sv
// Byte-stream program loader: frames an image into little-endian words, writes them
// to the icache and releases the core once the trailing XOR checksum matches.
module boot_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              ic_we_o,
   output logic [ADDR_W-1:0] ic_waddr_o,
   output logic [31:0]       ic_wdata_o,
   output logic              core_rst_no,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

   typedef enum logic [2:0] {S_HDR, S_LOAD, S_CHK, S_RUN, S_ERR} state_t;

   state_t            r_state;
   logic [7:0]        r_n;
   logic [7:0]        r_word_cnt;
   logic [1:0]        r_byte_idx;
   logic [7:0]        r_csum;
   logic [23:0]       r_lanes;
   logic              r_pend_p0;
   logic [ADDR_W-1:0] r_pend_addr_p0;
   logic [31:0]       r_pend_data_p0;
   logic              r_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_wdata;
   logic              r_done;
   logic              r_err;

   logic w_take;
   logic w_last_byte;
   logic w_last_word;

   assign w_take      = rx_valid_i & r_ready;
   assign w_last_byte = (r_byte_idx == 2'd3);
   assign w_last_word = (r_word_cnt == (r_n - 8'd1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_HDR;
         r_n        <= 8'd0;
         r_word_cnt <= 8'd0;
         r_byte_idx <= 2'd0;
         r_csum     <= 8'd0;
         r_pend_p0  <= 1'b0;
         r_ready    <= 1'b1;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= 32'd0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // stage p0 -> output: a completed word is written one edge after its 4th byte
         r_pend_p0 <= 1'b0;
         r_we      <= r_pend_p0;
         if (r_pend_p0) begin
            r_waddr <= r_pend_addr_p0;
            r_wdata <= r_pend_data_p0;
         end
         r_done <= (r_state == S_RUN);
         r_err  <= (r_state == S_ERR);

         unique case (r_state)
            S_HDR: begin
               if (w_take) begin
                  r_n        <= rx_data_i;
                  r_word_cnt <= 8'd0;
                  r_byte_idx <= 2'd0;
                  r_csum     <= 8'd0;
                  if (rx_data_i == 8'd0) begin
                     r_state <= S_CHK;
                  end else if ({24'd0, rx_data_i} > DEPTH) begin
                     r_state <= S_ERR;
                     r_ready <= 1'b0;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (w_take) begin
                  r_csum     <= r_csum ^ rx_data_i;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (w_last_byte) begin
                     r_pend_p0  <= 1'b1;
                     r_word_cnt <= r_word_cnt + 8'd1;
                     if (w_last_word) begin
                        r_state <= S_CHK;
                     end
                  end
               end
            end
            S_CHK: begin
               if (w_take) begin
                  r_ready <= 1'b0;
                  r_state <= (rx_data_i == r_csum) ? S_RUN : S_ERR;
               end
            end
            default: begin
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Byte lanes and the staged word carry no control meaning, so they are not reset.
   always_ff @(posedge clk_i) begin
      if (w_take && (r_state == S_LOAD)) begin
         if (w_last_byte) begin
            r_pend_data_p0 <= {rx_data_i, r_lanes};
            r_pend_addr_p0 <= ADDR_W'(r_word_cnt);
         end else begin
            r_lanes[{r_byte_idx, 3'b000} +: 8] <= rx_data_i;
         end
      end
   end

   assign rx_ready_o  = r_ready;
   assign ic_we_o     = r_we;
   assign ic_waddr_o  = r_waddr;
   assign ic_wdata_o  = r_wdata;
   assign core_rst_no = r_done;
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framing, write timing, checksum outcome, abort and full load.
module tb_boot_loader;

   logic        clk_i;
   logic        rst_ni;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic        ic_we_o;
   logic [5:0]  ic_waddr_o;
   logic [31:0] ic_wdata_o;
   logic        core_rst_no;
   logic        done_o;
   logic        err_o;

   int n_cmp;
   int n_fail;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t log_q[$];

   boot_loader #(.ADDR_W(6)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .ic_we_o    (ic_we_o),
      .ic_waddr_o (ic_waddr_o),
      .ic_wdata_o (ic_wdata_o),
      .core_rst_no(core_rst_no),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (ic_we_o === 1'b1) log_q.push_back({ic_waddr_o, ic_wdata_o});
   end

   // Tasks are entered and left 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         rx_valid_i = 1'b0;
         @(posedge clk_i); #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      n_cmp++;
      if (rx_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: rx_ready_o=%b required 1 for byte %h", rx_ready_o, b);
      end
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic apply_reset;
      rx_valid_i = 1'b0;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      log_q.delete();
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i = 8'h00;
      #12;
      n_cmp++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", rx_ready_o); end
      n_cmp++; if (ic_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", ic_we_o); end
      n_cmp++; if (ic_waddr_o !== 6'd0) begin n_fail++; $display("FAIL rst_waddr: got %h want 0", ic_waddr_o); end
      n_cmp++; if (ic_wdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", ic_wdata_o); end
      n_cmp++; if (core_rst_no !== 1'b0) begin n_fail++; $display("FAIL rst_core: got %b want 0", core_rst_no); end
      n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_load_n2;
      logic [7:0] f[10];
      f = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         send_byte(f[i], 0);
         if (i == 4) begin
            n_cmp++; if (ic_we_o !== 1'b0) begin n_fail++; $display("FAIL n2_we_early: got %b want 0", ic_we_o); end
         end
         if (i == 5) begin
            n_cmp++;
            if (ic_we_o !== 1'b1 || ic_waddr_o !== 6'd0 || ic_wdata_o !== 32'h00000013) begin
               n_fail++;
               $display("FAIL n2_we_lat: got we=%b a=%h d=%h want 1/00/00000013", ic_we_o, ic_waddr_o, ic_wdata_o);
            end
         end
         if (i == 6) begin
            n_cmp++; if (ic_we_o !== 1'b0) begin n_fail++; $display("FAIL n2_we_pulse: got %b want 0", ic_we_o); end
         end
      end
      n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL n2_done_early: got %b want 0", done_o); end
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL n2_ready: got %b want 0", rx_ready_o); end
      @(posedge clk_i); #1;
      n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL n2_done: got %b want 1", done_o); end
      n_cmp++; if (core_rst_no !== 1'b1) begin n_fail++; $display("FAIL n2_core: got %b want 1", core_rst_no); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL n2_err: got %b want 0", err_o); end
      n_cmp++;
      if (log_q.size() != 2 || log_q[0] !== {6'd0, 32'h00000013} || log_q[1] !== {6'd1, 32'h00100093}) begin
         n_fail++;
         $display("FAIL n2_writes: got %0d writes want 2 (0:00000013, 1:00100093)", log_q.size());
      end
   endtask

   task automatic test_bad_checksum;
      logic [7:0] f[10];
      f = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
      apply_reset();
      for (int i = 0; i < 10; i++) send_byte(f[i], 0);
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL bad_ready: got %b want 0", rx_ready_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL bad_err_early: got %b want 0", err_o); end
      rx_valid_i = 1'b1;
      rx_data_i = 8'h55;
      repeat (6) begin @(posedge clk_i); #1; end
      rx_valid_i = 1'b0;
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err_o); end
      n_cmp++; if (core_rst_no !== 1'b0) begin n_fail++; $display("FAIL bad_core: got %b want 0", core_rst_no); end
      n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL bad_done: got %b want 0", done_o); end
      n_cmp++; if (log_q.size() != 2) begin n_fail++; $display("FAIL bad_writes: got %0d writes want 2", log_q.size()); end
   endtask

   task automatic test_header_edges;
      apply_reset();
      send_byte(8'h41, 0);
      n_cmp++; if (err_o !== 1'b0 || rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got err=%b rdy=%b want 0/0", err_o, rx_ready_o); end
      @(posedge clk_i); #1;
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err_o); end
      n_cmp++; if (log_q.size() != 0) begin n_fail++; $display("FAIL ovf_writes: got %0d want 0", log_q.size()); end
      apply_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(posedge clk_i); #1;
      n_cmp++; if (done_o !== 1'b1 || core_rst_no !== 1'b1) begin n_fail++; $display("FAIL empty_done: got done=%b core=%b want 1/1", done_o, core_rst_no); end
      n_cmp++; if (log_q.size() != 0) begin n_fail++; $display("FAIL empty_writes: got %0d want 0", log_q.size()); end
   endtask

   task automatic test_gaps;
      logic [7:0] f[10];
      f = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      apply_reset();
      for (int i = 0; i < 10; i++) send_byte(f[i], int'($urandom_range(0, 5)));
      @(posedge clk_i); #1;
      n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b want 1", done_o); end
      n_cmp++;
      if (log_q.size() != 2 || log_q[0] !== {6'd0, 32'h00000013} || log_q[1] !== {6'd1, 32'h00100093}) begin
         n_fail++;
         $display("FAIL gap_writes: got %0d writes want 2 (0:00000013, 1:00100093)", log_q.size());
      end
   endtask

   task automatic test_abort;
      logic [7:0] f[7];
      logic [7:0] g[6];
      f = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      g = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      apply_reset();
      for (int i = 0; i < 7; i++) send_byte(f[i], 0);
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (rx_ready_o !== 1'b1 || ic_we_o !== 1'b0 || ic_waddr_o !== 6'd0 || ic_wdata_o !== 32'd0 ||
          core_rst_no !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got rdy=%b we=%b a=%h d=%h core=%b done=%b err=%b want 1/0/00/00000000/0/0/0",
                  rx_ready_o, ic_we_o, ic_waddr_o, ic_wdata_o, core_rst_no, done_o, err_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      log_q.delete();
      for (int i = 0; i < 6; i++) send_byte(g[i], 0);
      @(posedge clk_i); #1;
      n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b want 1", done_o); end
      n_cmp++;
      if (log_q.size() != 1 || log_q[0] !== {6'd0, 32'hDDCCBBAA}) begin
         n_fail++;
         $display("FAIL abort_writes: got %0d writes want 1 (0:DDCCBBAA)", log_q.size());
      end
   endtask

   task automatic test_full_load;
      logic [7:0] b;
      logic [7:0] csum;
      logic [31:0] exp_w;
      int cyc;
      apply_reset();
      csum = 8'h00;
      send_byte(8'h40, 0);
      cyc = 0;
      for (int k = 0; k < 64; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = 8'((k * 4 + j) ^ 8'hA5);
            csum = csum ^ b;
            send_byte(b, 0);
            cyc++;
         end
      end
      send_byte(csum, 0);
      cyc++;
      while (done_o !== 1'b1 && cyc < 700) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      n_cmp++; if (cyc != 258) begin n_fail++; $display("FAIL full_release: got %0d cycles want 258", cyc); end
      n_cmp++; if (log_q.size() != 64) begin n_fail++; $display("FAIL full_count: got %0d writes want 64", log_q.size()); end
      for (int k = 0; k < 64 && k < log_q.size(); k++) begin
         for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'((k * 4 + j) ^ 8'hA5);
         n_cmp++;
         if (log_q[k] !== {6'(k), exp_w}) begin
            n_fail++;
            $display("FAIL full_word%0d: got a=%h d=%h want a=%h d=%h", k, log_q[k].a, log_q[k].d, 6'(k), exp_w);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_load_n2();
      test_bad_checksum();
      test_header_edges();
      test_gaps();
      test_abort();
      test_full_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Program loader that sits directly upstream of the single-cycle core's instruction cache. It receives a framed program image as a byte stream, assembles little-endian 32-bit words and writes them into the icache through its write port. It holds the core in reset until the image is loaded and its checksum verifies, then releases it so execution starts at PC 0.

## Interface
- ADDR_W, 6, icache word-address width; DEPTH = 2^ADDR_W words (64 by default, matches the icache word address PC[7:2])
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- rx_data_i  input  8  incoming byte
- rx_valid_i  input  1  rx_data_i valid
- rx_ready_o  output  1  loader can accept a byte; byte is taken on a rising edge with rx_valid_i & rx_ready_o
- ic_we_o  output  1  icache write strobe, one-cycle pulse per word
- ic_waddr_o  output  ADDR_W  icache word address
- ic_wdata_o  output  32  icache write data
- core_rst_no  output  1  active-low reset to the core; low until load succeeds
- done_o  output  1  load succeeded, core running
- err_o  output  1  load failed, sticky until rst_ni

## Operation
- Frame: header byte N (word count), then 4*N data bytes, then one checksum byte = XOR of all 4*N data bytes (header excluded).
- Word assembly little-endian: 1st byte of a word -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
- Words written to addresses 0, 1, ..., N-1 in order.
- States: HDR, LOAD, CHK, RUN, ERR. Reset state HDR.
- HDR: rx_ready_o=1. On accepted header: N=0 -> CHK (expected checksum 0x00); 1<=N<=DEPTH -> LOAD, word count and byte index cleared; N>DEPTH -> ERR.
- LOAD: rx_ready_o=1. Each accepted byte XORed into running checksum and placed in its byte lane. On the 4th byte of word k: ic_waddr_o=k, ic_wdata_o=assembled word, ic_we_o=1 for exactly the next cycle. After word N-1's 4th byte -> CHK.
- CHK: rx_ready_o=1. Accepted byte equal to running checksum -> RUN; otherwise -> ERR.
- RUN: rx_ready_o=0, core_rst_no=1, done_o=1. Terminal until rst_ni.
- ERR: rx_ready_o=0, core_rst_no=0, err_o=1. Terminal until rst_ni.
- Bytes with rx_valid_i=0 are ignored; gaps of any length between bytes are legal anywhere in the frame.
- ic_waddr_o and ic_wdata_o hold their last value when ic_we_o=0.

## Timing
- Reset values: rx_ready_o=1, ic_we_o=0, ic_waddr_o=0, ic_wdata_o=0, core_rst_no=0, done_o=0, err_o=0; state HDR, checksum 0.
- All outputs registered. Asserting rst_ni mid-frame aborts immediately: outputs return to reset values, any partially written icache contents are left as they are, and the next frame starts from HDR.
- Write latency: ic_we_o rises on the edge after the edge that accepts a word's 4th byte. No back-pressure during LOAD; back-to-back bytes every cycle are sustained because a write always finishes before the next word's 4th byte arrives.
- Release: core_rst_no and done_o rise on the edge after the checksum byte is accepted. The final ic_we_o pulse completes no later than that same edge, so the core never fetches a stale word.
- err_o rises on the edge after the offending header or checksum byte is accepted.
- Minimum frame time with continuous valid: 4N+2 cycles from first header byte to release.

## Test plan
- Load N=2: bytes 02, 13 00 00 00, 93 00 10 00, 00 -> ic_we_o pulses (addr 0, 0x00000013) then (addr 1, 0x00100093); checksum byte 0x13^0x93^0x10=0x90, so use trailer 90 -> done_o=1, core_rst_no=1 one cycle after the trailer.
- Bad checksum: same frame with trailer 00 -> err_o=1, core_rst_no stays 0, rx_ready_o=0, no further writes.
- Header 0x41 (65 > DEPTH 64) -> err_o=1 after one cycle, no ic_we_o pulse; header 0x00 then trailer 0x00 -> done_o=1, no writes.
- Random rx_valid_i gaps (0-5 idle cycles) on the N=2 frame -> identical write sequence and release.
- rst_ni pulsed low after the 6th data byte -> all outputs at reset values immediately; a full new N=1 frame (01, AA BB CC DD, trailer 00) then writes 0xDDCCBBAA to addr 0 and releases the core.
- Full load N=64 with continuous valid -> 64 writes at addresses 0..63, release exactly 258 cycles after the header is accepted.
